uart_tx_sequencer: RTL

Frame sequencer that owns the shared baud counter on the UART transmit path. Accepts bytes on a valid/ready handshake and programs the counter's divisor and enable. Each completed counter interval (baud_tick) advances the serial line through start, data, optional parity and stop bits. Sits between the host-side byte source and the baud_counter instance; drives the tx pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame states, parity modes
// and the default baud divisor width.
package uart_pkg;

    localparam int DIV_W_DEFAULT = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: accepts bytes on valid/ready, drives the shared
// baud counter and steps tx through start, data, optional parity and stop bits.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = DIV_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    input  logic [DIV_W-1:0]     cfg_baud,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic [DIV_W-1:0]     baud_div,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_err
);

    localparam int CNT_W = $clog2(DATA_BITS);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;
    logic [DIV_W-1:0]       baud_div_q, baud_div_d;
    logic                   baud_en_q, baud_en_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic                   idle;
    logic                   accept;
    logic                   tick;
    logic                   last_bit;
    logic                   stop_extend;

    assign idle        = (state_q == ST_IDLE);
    assign in_ready    = idle && (cfg_baud != '0) && rstn;
    assign cfg_err     = idle && (cfg_baud == '0) && rstn;
    assign accept      = in_valid && in_ready;
    // Ticks left over from a previous frame or arriving while disabled are ignored.
    assign tick        = baud_tick && baud_en_q && !idle;
    assign last_bit    = (bit_cnt_q == CNT_W'(DATA_BITS - 1));
    assign stop_extend = stop2_q && (stop_cnt_q == 1'b0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            baud_div_q   <= '0;
            baud_en_q    <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            baud_div_q   <= baud_div_d;
            baud_en_q    <= baud_en_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA:   if (tick && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick && !stop_extend) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The data shift register keeps the bit currently on the line at index 0.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        baud_div_d   = baud_div_q;
        baud_en_d    = baud_en_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        if (idle) begin
            if (accept) begin
                shift_d    = in_data;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                par_bit_d  = (cfg_parity == PAR_ODD) ? ~(^in_data) : (^in_data);
                stop2_d    = cfg_stop2;
                baud_div_d = cfg_baud;
                baud_en_d  = 1'b1;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
            end
        end else if (tick) begin
            unique case (state_q)
                ST_START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    if (last_bit) begin
                        tx_d       = par_en_q ? par_bit_q : 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[1];
                    end
                end
                ST_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                ST_STOP: begin
                    tx_d = 1'b1;
                    if (stop_extend) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        baud_en_d    = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign baud_en    = baud_en_q;
    assign baud_div   = baud_div_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
